// File: rtl/generador_sensor_estacionamiento_pkg.sv
// generador_sensor_estacionamiento_pkg: sensor codes, state encoding and pattern lookup
package generador_sensor_estacionamiento_pkg;
  localparam logic [1:0] LIBRE    = 2'b00;
  localparam logic [1:0] A_BLOCK  = 2'b10;
  localparam logic [1:0] AB_BLOCK = 2'b11;
  localparam logic [1:0] B_BLOCK  = 2'b01;
  typedef enum logic [2:0] {IDLE, F1, F2, F3, HUECO} estado_t;
  function automatic logic [1:0] patron(estado_t e, logic d);
    return e == F1 ? (d ? B_BLOCK : A_BLOCK) :
           e == F2 ? AB_BLOCK :
           e == F3 ? (d ? A_BLOCK : B_BLOCK) : LIBRE;
  endfunction
endpackage

// File: rtl/generador_sensor_estacionamiento_contador_fase.sv
// contador_fase: loadable down-counter with terminal-count flag for phase timing
module contador_fase #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] valor,
  output logic         tc
);
  logic [W-1:0] cnt;
  // reload on phase change, otherwise count down and hold at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= valor;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign tc = cnt == '0;
endmodule

// File: rtl/generador_sensor_estacionamiento.sv
// generador_sensor_estacionamiento: replays entry/exit two-beam sensor patterns and tracks occupancy
module generador_sensor_estacionamiento
  import generador_sensor_estacionamiento_pkg::*;
#(
  parameter int DWELL = 1,
  parameter int GAP = 2,
  parameter int CAPACIDAD = 8,
  localparam int OCC_W = $clog2(CAPACIDAD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_entrada,
  input  logic             req_salida,
  output logic [1:0]       sensor,
  output logic             listo,
  output logic             fin,
  output logic             rechazo,
  output logic [OCC_W-1:0] ocupacion
);
  localparam int MX = DWELL > GAP ? DWELL : GAP;
  localparam int CW = $clog2(MX + 1);
  estado_t state, state_n;
  logic dir, dir_n, tc, acc_e, acc_s, rej, load;
  logic [CW-1:0] valor;
  assign acc_e = req_entrada && !req_salida && ocupacion < OCC_W'(CAPACIDAD);
  assign acc_s = req_salida && !req_entrada && ocupacion != '0;
  assign rej = state == IDLE && (req_entrada || req_salida) && !acc_e && !acc_s;
  assign load = state_n != state;
  assign valor = state_n == HUECO ? CW'(GAP - 1) : CW'(DWELL - 1);
  contador_fase #(.W(CW)) u_contador (
    .clk(clk), .rst_n(rst_n), .load(load), .valor(valor), .tc(tc)
  );
  // state and direction registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      dir <= 1'b0;
    end else begin
      state <= state_n;
      dir <= dir_n;
    end
  // admission in IDLE, then fixed phase order advanced by the counter
  always_comb begin
    state_n = state;
    dir_n = dir;
    if (state == IDLE) begin
      if (acc_e || acc_s) begin
        state_n = F1;
        dir_n = acc_s;
      end
    end else if (tc)
      state_n = state == F1 ? F2 : state == F2 ? F3 : state == F3 ? HUECO : IDLE;
  end
  // registered outputs derived from the upcoming state so they align with it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sensor <= LIBRE;
      listo <= 1'b1;
      fin <= 1'b0;
      rechazo <= 1'b0;
      ocupacion <= '0;
    end else begin
      sensor <= patron(state_n, dir_n);
      listo <= state_n == IDLE;
      fin <= state == HUECO && tc;
      rechazo <= rej;
      if (state == HUECO && tc) ocupacion <= dir ? ocupacion - OCC_W'(1) : ocupacion + OCC_W'(1);
    end
endmodule
